// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the fetch/data memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  // Default number of wait cycles before a transaction is abandoned
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // Width of the wait counter
  localparam int unsigned CNT_W = 8;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin tie-break between fetch and data sides.
//                The last-grant flag starts at fetch, so data wins the first
//                tie. Only grants issued while enabled update the flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_f_i,
  input  logic req_d_i,
  output logic gnt_f_o,
  output logic gnt_d_o
);

  logic last_d_q;  // 1: data side won the most recent arbitration

  // Grant the single requester, or on a tie the side not granted last
  always_comb begin
    gnt_f_o = 1'b0;
    gnt_d_o = 1'b0;
    if (en_i) begin
      if (req_f_i && req_d_i) begin
        gnt_d_o = ~last_d_q;
        gnt_f_o = last_d_q;
      end else begin
        gnt_f_o = req_f_i;
        gnt_d_o = req_d_i;
      end
    end
  end

  // Remember which side won the last arbitration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (gnt_d_o) begin
      last_d_q <= 1'b1;
    end else if (gnt_f_o) begin
      last_d_q <= 1'b0;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates a shared memory port between a fetch (read-only)
//                requester and a data (read/write) requester, with
//                back-to-back service, a wait timeout and pipeline stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_valid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_valid,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stall_F,
  output logic             stall_M,
  output logic             err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic               if_valid_q, if_valid_d;
  logic               d_valid_q, d_valid_d;
  logic [WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               if_pend, d_pend;
  logic               arb_en, gnt_f, gnt_d;
  logic               load_i, load_d;
  logic [CNT_W-1:0]   cnt_inc;

  // A requester still holding req while its valid pulse is out has already
  // been served; masking it prevents a spurious re-grant.
  assign if_pend = if_req & ~if_valid_q;
  assign d_pend  = d_req & ~d_valid_q;
  assign arb_en  = (state_q == IDLE);
  assign cnt_inc = cnt_q + 1'b1;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .req_f_i (if_pend),
    .req_d_i (d_pend),
    .gnt_f_o (gnt_f),
    .gnt_d_o (gnt_d)
  );

  // Next-state, memory command and completion logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_i      = 1'b0;
    load_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Stray acks are ignored here; only the arbiter result matters
        load_d = gnt_d;
        load_i = gnt_f;
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack) begin
          if (state_q == GRANT_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
            load_d     = d_pend;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            load_i = if_pend;
          end
          if (!(load_i || load_d)) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            // Abandon the transaction and complete it with zero data
            err_d     = 1'b1;
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (state_q == GRANT_I) begin
              if_valid_d = 1'b1;
              if_rdata_d = '0;
            end else begin
              d_valid_d = 1'b1;
              d_rdata_d = '0;
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    // Register the granted command; fetch is always a read
    if (load_d) begin
      state_d     = GRANT_D;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      cnt_d       = '0;
    end else if (load_i) begin
      state_d     = GRANT_I;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      cnt_d       = '0;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign stall_F   = if_req & ~if_valid_q;
  assign stall_M   = d_req & ~d_valid_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed corner-case
//                sequences plus a table of single transactions, with a
//                completion scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_F;
  logic        stall_M;
  logic        err;

  mem_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_F   (stall_F),
    .stall_M   (stall_M),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected completions, in completion order
  typedef struct packed {
    logic        side;   // 1: data, 0: fetch
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (if_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_if_valid", {31'b0, if_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_side_if", 32'd0, {31'b0, mon_e.side});
        chk("sb_if_rdata", if_rdata, mon_e.rdata);
      end
    end
    if (d_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_d_valid", {31'b0, d_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_side_d", 32'd1, {31'b0, mon_e.side});
        chk("sb_d_rdata", d_rdata, mon_e.rdata);
      end
    end
  end

  // Single-transaction vectors: stimulus plus expected completion data
  typedef struct {
    logic        d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];
  vec_t v;

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("mem_req_seen", {31'b0, mem_req}, 32'd1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Vector table (d_rdata model: 0 after the timeout test)
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,          32'h1234_5678, 0, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0055,  32'hAAAA_5555, 3, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          32'h0BAD_F00D, 5, 32'h0BAD_F00D};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 1, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_BABE,  32'h5A5A_5A5A, 0, 32'hFFFF_FFFF};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

    // ---- Reset state ----
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    repeat (2) @(negedge clk);

    // ---- Tie after reset: data first, fetch back-to-back ----
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    sb_q.push_back('{1'b1, 32'h1111_0000});
    sb_q.push_back('{1'b0, 32'h2222_0000});
    @(negedge clk);
    chk("tie1_first_grant_req", {31'b0, mem_req}, 32'd1);
    chk("tie1_first_addr", mem_addr, 32'h2000);
    chk("tie1_stall_F", {31'b0, stall_F}, 32'd1);
    chk("tie1_stall_M", {31'b0, stall_M}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    @(negedge clk);
    chk("b2b_d_valid", {31'b0, d_valid}, 32'd1);
    chk("b2b_mem_req", {31'b0, mem_req}, 32'd1);
    chk("b2b_addr", mem_addr, 32'h0);
    d_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h2222_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_if_valid", {31'b0, if_valid}, 32'd1);
    chk("b2b_d_valid_single", {31'b0, d_valid}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'b0, mem_req}, 32'd0);

    // ---- Second tie goes to fetch ----
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400;
    sb_q.push_back('{1'b0, 32'h3333_0000});
    sb_q.push_back('{1'b1, 32'h4444_0000});
    @(negedge clk);
    chk("tie2_fetch_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h3333_0000;
    @(negedge clk);
    if_req = 1'b0;
    chk("tie2_b2b_addr", mem_addr, 32'h400);
    mem_ack = 1'b1; mem_rdata = 32'h4444_0000;
    @(negedge clk);
    mem_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("tie2_idle", {31'b0, mem_req}, 32'd0);

    // ---- Stray ack in IDLE ----
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
    chk("stray_if_valid", {31'b0, if_valid}, 32'd0);
    chk("stray_d_valid", {31'b0, d_valid}, 32'd0);
    chk("stray_d_rdata", d_rdata, 32'h4444_0000);

    // ---- Timeout on a data read ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    sb_q.push_back('{1'b1, 32'h0});
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 32'd15);
    chk("timeout_mem_req", {31'b0, mem_req}, 32'd0);
    chk("timeout_d_valid", {31'b0, d_valid}, 32'd1);
    chk("timeout_err", {31'b0, err}, 32'd1);
    d_req = 1'b0;

    // ---- Table of single transactions ----
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      @(negedge clk);
      if (v.d) begin
        d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
        if_req = 1'b1; if_addr = v.addr;
      end
      sb_q.push_back('{v.d, v.exp_rdata});
      wait_req();
      chk("vec_mem_addr", mem_addr, v.addr);
      chk("vec_mem_we", {31'b0, mem_we}, {31'b0, v.d & v.we});
      if (v.d && v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
      chk("vec_stall_on", {31'b0, v.d ? stall_M : stall_F}, 32'd1);
      for (int k = 0; k < v.lat; k++) begin
        @(negedge clk);
        chk("vec_hold", {31'b0, (mem_req && mem_addr == v.addr &&
                                 mem_we == (v.d & v.we))}, 32'd1);
      end
      mem_ack = 1'b1; mem_rdata = v.mrdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      chk("vec_valid", {31'b0, v.d ? d_valid : if_valid}, 32'd1);
      chk("vec_err_sticky", {31'b0, err}, 32'd1);
      if (v.d) d_req = 1'b0; else if_req = 1'b0;
      @(negedge clk);
      chk("vec_valid_single", {31'b0, v.d ? d_valid : if_valid}, 32'd0);
      chk("vec_stall_off", {31'b0, v.d ? stall_M : stall_F}, 32'd0);
      chk("vec_idle", {31'b0, mem_req}, 32'd0);
    end

    // ---- Reset in the middle of a data transaction ----
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h7777_7777;
    wait_req();
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_if_rdata", if_rdata, 32'd0);
    chk("arst_d_rdata", d_rdata, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    chk("arst_valids", {30'b0, if_valid, d_valid}, 32'd0);
    d_req = 1'b0; mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_d_valid", {31'b0, d_valid}, 32'd0);
    chk("arst_after_idle", {31'b0, mem_req}, 32'd0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the address and data width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles to wait for mem_ack; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 if_req  input  1  SHALL be the fetch-side request, held until if_valid.
REQ-006 if_addr  input  WIDTH  SHALL be the fetch address.
REQ-007 if_rdata  output  WIDTH  SHALL be the fetch read data.
REQ-008 if_valid  output  1  SHALL be a one-cycle pulse marking fetch completion.
REQ-009 d_req  input  1  SHALL be the data-side request, held until d_valid.
REQ-010 d_we  input  1  SHALL select a data-side write (1) or read (0).
REQ-011 d_addr, d_wdata  input  WIDTH each  SHALL be the data-side address and write data.
REQ-012 d_rdata  output  WIDTH  SHALL be the data-side read data.
REQ-013 d_valid  output  1  SHALL be a one-cycle pulse marking data-side completion.
REQ-014 mem_req, mem_we  output  1 each  SHALL be the shared-memory request and write enable.
REQ-015 mem_addr, mem_wdata  output  WIDTH each  SHALL be the shared-memory address and write data.
REQ-016 mem_rdata  input  WIDTH  SHALL be the shared-memory read data, valid with mem_ack.
REQ-017 mem_ack  input  1  SHALL be the shared-memory one-cycle completion strobe.
REQ-018 stall_F, stall_M  output  1 each  SHALL be the pipeline stall requests for the fetch and memory stages.
REQ-019 err  output  1  SHALL be a sticky timeout flag.

Function
REQ-020 The block SHALL implement the FSM states IDLE, GRANT_I, GRANT_D.
REQ-021 IDLE SHALL go to GRANT_D if only d_req is set, and to GRANT_I if only if_req is set.
REQ-022 IDLE with both requests set SHALL grant the side not granted last; the last-grant flag resets to fetch, so data wins the first tie.
REQ-023 On grant, the block SHALL register the granted addr, we, and wdata; fetch is always a read.
REQ-024 mem_req SHALL be asserted from the cycle after the grant until the cycle mem_ack is sampled high; mem_* outputs SHALL be stable throughout.
REQ-025 On mem_ack, the block SHALL capture mem_rdata into the granted side's rdata register and pulse that side's valid for one cycle.
REQ-026 On mem_ack with the other request pending, the block SHALL go directly to the other grant state (back-to-back).
REQ-027 On mem_ack with no other request pending, the block SHALL return to IDLE.
REQ-028 A write SHALL pulse d_valid on mem_ack and leave d_rdata unchanged.
REQ-029 A wait counter (8 bits) SHALL clear on grant and increment every cycle mem_req is high without mem_ack.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL set err, drop mem_req, pulse the granted valid with rdata 0, and return to IDLE.
REQ-031 mem_ack in IDLE SHALL be ignored.
REQ-032 if_rdata and d_rdata SHALL hold their values until the next completion on the same side.
REQ-033 stall_F SHALL be combinational: if_req and not if_valid.
REQ-034 stall_M SHALL be combinational: d_req and not d_valid.
REQ-035 A request deasserted before its grant SHALL be dropped; once granted, it SHALL complete regardless of requester deassertion.

Reset
REQ-036 While rst is low, the block SHALL force: state IDLE, last-grant fetch, counter 0, err 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, if_valid/d_valid 0, if_rdata/d_rdata 0.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no valid pulse.
REQ-038 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-039 The FSM state enum and the TIMEOUT default SHALL reside in shared package mem_pkg.
REQ-040 The block SHALL be a single module; the round-robin tie-break SHALL be one sub-module, rr_arb2.

Verification
REQ-041 Fetch read: if_req, addr 0x100, mem_ack at cycle 3 with 0xDEADBEEF -> if_valid single pulse with if_rdata=0xDEADBEEF, stall_F low the cycle after.
REQ-042 Simultaneous requests after reset: fetch 0x0, data read 0x2000 -> data served first, fetch back-to-back with no IDLE cycle; a second tie is granted to fetch.
REQ-043 Data write: d_we=1, addr 0x10, wdata 0x55 -> mem_we=1, mem_wdata=0x55 stable until ack; d_rdata unchanged.
REQ-044 Timeout: mem_ack never arrives, TIMEOUT=15 -> mem_req drops after 15 wait cycles; err=1 sticky; d_valid pulses with 0.
REQ-045 Reset mid-transaction: rst low during GRANT_D -> all outputs 0 immediately (asynchronous), no d_valid pulse.
REQ-046 Stray ack: mem_ack pulsed in IDLE -> no valid pulse, no state change.
